// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: widths and FSM states shared by the RAM read and write sequencers
package ram_stream_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/ram_stream_skid.sv
// ram_stream_skid: 2-entry FIFO carrying each RAM byte with its end-of-burst flag
module ram_stream_skid #(
    parameter int DATA_W = ram_stream_pkg::DATA_W_DEF
) (
    input  logic              clk_w,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] data,
    output logic              last
);
    logic [DATA_W-1:0] mem [2];
    logic [1:0]        lst;
    logic              wr, rd;
    always_ff @(posedge clk_w) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            lst    <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= push_data;
                lst[wr] <= push_last;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    assign data = mem[rd];
    assign last = lst[rd];
endmodule

// File: rtl/ram_read_streamer.sv
// ram_read_streamer: streams a burst of bytes from a registered-read RAM onto a ready/valid port
module ram_read_streamer #(
    parameter int DATA_W = ram_stream_pkg::DATA_W_DEF,
    parameter int ADDR_W = ram_stream_pkg::ADDR_W_DEF
) (
    input  logic              read_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import ram_stream_pkg::*;
    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        fifo_count;
    logic              inflight, inflight_last, zl_done;
    logic              accept, zero_req, pop, issue, last_issue, drain_done;
    // Issue only while the FIFO plus the byte still in the RAM pipe leaves room, so it never overflows
    always_comb begin
        accept     = state == IDLE && start && length != '0;
        zero_req   = state == IDLE && start && length == '0;
        pop        = out_valid && out_ready;
        issue      = state == RUN && ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        last_issue = issue && remaining == (ADDR_W+1)'(1);
        drain_done = state == DRAIN && pop && out_last && fifo_count == 2'd1 && !inflight;
        state_n    = accept ? RUN : last_issue ? DRAIN : drain_done ? IDLE : state;
    end
    always_ff @(posedge read_clock) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zl_done       <= 1'b0;
        end else begin
            state         <= state_n;
            inflight      <= issue;
            inflight_last <= last_issue;
            zl_done       <= zero_req;
            if (accept) begin
                ptr       <= base_addr;
                remaining <= length;
            end else if (issue) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
        end
    end
    ram_stream_skid #(.DATA_W(DATA_W)) u_skid (
        .clk_w    (read_clock),
        .reset    (reset),
        .push     (inflight),
        .push_data(q),
        .push_last(inflight_last),
        .pop      (pop),
        .count    (fifo_count),
        .data     (out_data),
        .last     (out_last)
    );
    assign read_addr = ptr;
    assign out_valid = fifo_count != 2'd0;
    assign busy      = state != IDLE;
    assign done      = zl_done | drain_done;
endmodule

// File: tb/tb_ram_read_streamer.sv
// tb_ram_read_streamer: table, hand-timed and random bursts against a byte-sequence model
module tb_ram_read_streamer;
    localparam int DW = 8;
    localparam int AW = 6;

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_first;
        int exp_last;
    } vec_t;

    logic          read_clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] q, out_data;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] ram [64];

    int vectors = 0;
    int miscompares = 0;
    int rx_data[$];
    int rx_lastf[$];
    int done_count = 0;
    int busy_count = 0;
    int valid_count = 0;
    bit prev_stall = 0;
    int prev_data, prev_last;

    always #5 read_clock = ~read_clock;
    always @(posedge read_clock) q <= ram[read_addr];

    ram_read_streamer dut (
        .read_clock(read_clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .read_addr (read_addr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic int model_byte(input int a);
        return ((a % 64) + 16) & 255;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observe the port at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        @(negedge read_clock);
        if (reset) prev_stall = 0;
        else begin
            if (prev_stall) begin
                check("hold_data", int'(out_data), prev_data);
                check("hold_valid", int'(out_valid), 1);
                check("hold_last", int'(out_last), prev_last);
            end
            if (out_valid) check("fifo_bound", int'(dut.u_skid.count <= 2'd2), 1);
            if (busy) busy_count++;
            if (out_valid) valid_count++;
            if (done) done_count++;
            if (out_valid && out_ready) begin
                rx_data.push_back(int'(out_data));
                rx_lastf.push_back(int'(out_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            prev_last  = int'(out_last);
        end
        @(posedge read_clock);
        #1;
    endtask

    task automatic run_burst(input int base, input int len, input int mode, input int restart_at,
                             output int nb, output int first, output int lastb, output int nd);
        int s, d0, b0, v0;
        bit fin, tog;
        s = rx_data.size(); d0 = done_count; b0 = busy_count; v0 = valid_count;
        fin = 0; tog = 0;
        base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            start = (c == restart_at);
            if (start) begin
                base_addr = AW'(40);
                length = (AW+1)'(5);
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
            tog = !tog;
            tick();
            fin = done_count > d0 && !busy;
        end
        start = 1'b0;
        if (!fin) check("burst_timeout", 0, 1);
        out_ready = 1'b1;
        repeat (3) tick();
        nb = rx_data.size() - s;
        nd = done_count - d0;
        first = nb > 0 ? rx_data[s] : -1;
        lastb = nb > 0 ? rx_data[rx_data.size()-1] : -1;
        for (int i = 0; i < nb && i < len; i++) begin
            check("byte", rx_data[s+i], model_byte(base + i));
            check("last_flag", rx_lastf[s+i], int'(i == len - 1));
        end
        if (len == 0) begin
            check("zl_busy", busy_count - b0, 0);
            check("zl_valid", valid_count - v0, 0);
        end
    endtask

    // Continuous-ready burst with every output checked against its exact cycle after start
    task automatic run_timed(input int base, input int len);
        base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= len + 3; k++) begin
            tick();
            start = 1'b0;
            if (k <= len) check("rd_addr_t", int'(read_addr), (base + k - 1) % 64);
            check("valid_t", int'(out_valid), int'(k >= 3 && k <= len + 2));
            if (out_valid) begin
                check("data_t", int'(out_data), model_byte(base + k - 3));
                check("last_t", int'(out_last), int'(k == len + 2));
            end
            check("done_t", int'(done), int'(k == len + 2));
            check("busy_t", int'(busy), int'(k <= len + 2));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, int'(read_addr), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_last"}, int'(out_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int nb, first, lastb, nd, s, d0, v0, base, len;
        bit got;
        for (int i = 0; i < 64; i++) ram[i] = DW'(i + 16);
        vecs[0] = '{5, 4, 0, 'h15, 'h18};
        vecs[1] = '{62, 4, 0, 'h4E, 'h11};
        vecs[2] = '{0, 64, 1, 'h10, 'h4F};
        vecs[3] = '{63, 1, 2, 'h4F, 'h4F};
        vecs[4] = '{10, 0, 0, -1, -1};
        vecs[5] = '{33, 64, 2, 'h31, 'h30};

        repeat (2) tick();
        check_zero("rst");
        reset = 1'b0;
        tick();
        check_zero("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, -1, nb, first, lastb, nd);
            check("tbl_count", nb, vecs[i].len);
            check("tbl_first", first, vecs[i].exp_first);
            check("tbl_last", lastb, vecs[i].exp_last);
            check("tbl_done", nd, 1);
        end

        run_timed(5, 4);
        run_timed(62, 4);
        run_timed(60, 1);

        // Reset after three of ten bytes, then a fresh short burst
        s = rx_data.size();
        base_addr = '0; length = (AW+1)'(10); start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            tick();
            got = rx_data.size() - s >= 3;
        end
        check("reset_wait", int'(got), 1);
        d0 = done_count;
        reset = 1'b1;
        tick();
        check_zero("mid_rst");
        reset = 1'b0;
        v0 = valid_count;
        tick();
        check_zero("mid_post");
        repeat (5) tick();
        check("no_done_after_rst", done_count - d0, 0);
        check("no_valid_after_rst", valid_count - v0, 0);
        run_burst(0, 2, 0, -1, nb, first, lastb, nd);
        check("rst_new_count", nb, 2);
        check("rst_new_first", first, 'h10);
        check("rst_new_last", lastb, 'h11);
        check("rst_new_done", nd, 1);

        // Second start while busy must be ignored
        run_burst(20, 8, 1, 3, nb, first, lastb, nd);
        check("busy_start_count", nb, 8);
        check("busy_start_last", lastb, 'h2B);
        check("busy_start_done", nd, 1);

        for (int r = 0; r < 20; r++) begin
            base = $urandom_range(0, 63);
            len = $urandom_range(0, 64);
            run_burst(base, len, 2, -1, nb, first, lastb, nd);
            check("rnd_count", nb, len);
            check("rnd_first", first, len > 0 ? model_byte(base) : -1);
            check("rnd_last", lastb, len > 0 ? model_byte(base + len - 1) : -1);
            check("rnd_done", nd, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
